// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the pipelined MIPS core.
// Tolerates variable-latency imem through a one-entry fetch buffer and a redirect register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {RUN, WAIT, BUF, DRAIN} state_t;

  state_t      state, stateNext;
  logic [31:0] pcF, pcFNext, pcPlus4F;
  logic [31:0] fetchBufInstr, fetchBufInstrNext;
  logic [31:0] fetchBufPc, fetchBufPcNext;
  logic [31:0] redirReg, redirRegNext;
  logic [31:0] instrDNext, pcPlus4DNext;
  logic        validDNext;
  logic        redir;
  logic [31:0] target;
  logic        loadNop, loadMem, loadBuf;

  assign redir    = (JumpD | PCSrcD) & ~StallD;
  assign target   = JumpD ? PCJumpD : PCBranchD;
  assign pcPlus4F = pcF + 32'd4;

  assign imem_addr = pcF;

  // Request depends only on state, StallF and reset so imem_ready never feeds back.
  always_comb begin
    imem_req = 1'b1;
    case (state)
      RUN:     imem_req = ~StallF;
      BUF:     imem_req = 1'b0;
      default: imem_req = 1'b1;
    endcase
    if (reset) imem_req = 1'b0;
  end

  always_comb begin
    stateNext         = state;
    pcFNext           = pcF;
    fetchBufInstrNext = fetchBufInstr;
    fetchBufPcNext    = fetchBufPc;
    redirRegNext      = redirReg;
    loadNop           = 1'b0;
    loadMem           = 1'b0;
    loadBuf           = 1'b0;

    case (state)
      RUN: begin
        if (!StallF) begin
          if (imem_ready) begin
            if (redir) begin
              pcFNext = target;
              loadNop = 1'b1;
            end else begin
              pcFNext = pcPlus4F;
              loadMem = 1'b1;
            end
          end else begin
            loadNop = 1'b1;
            if (redir) begin
              redirRegNext = target;
              stateNext    = DRAIN;
            end else begin
              stateNext = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (!imem_ready) begin
          if (redir) begin
            redirRegNext = target;
            loadNop      = 1'b1;
            stateNext    = DRAIN;
          end else if (!StallD) begin
            loadNop = 1'b1;
          end
        end else if (redir) begin
          pcFNext   = target;
          loadNop   = 1'b1;
          stateNext = RUN;
        end else if (StallD) begin
          // Decode is frozen: park the returned word until IF/ID can take it.
          fetchBufInstrNext = imem_rdata;
          fetchBufPcNext    = pcPlus4F;
          pcFNext           = pcPlus4F;
          stateNext         = BUF;
        end else begin
          loadMem   = 1'b1;
          pcFNext   = pcPlus4F;
          stateNext = RUN;
        end
      end
      BUF: begin
        if (redir) begin
          pcFNext   = target;
          loadNop   = 1'b1;
          stateNext = RUN;
        end else if (!StallD) begin
          loadBuf   = 1'b1;
          stateNext = RUN;
        end
      end
      DRAIN: begin
        // The outstanding request must complete before the redirect target is issued.
        loadNop = 1'b1;
        if (imem_ready) begin
          pcFNext   = redirReg;
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    instrDNext   = InstrD;
    pcPlus4DNext = PCPlus4D;
    validDNext   = ValidD;
    if (loadNop) begin
      instrDNext   = '0;
      pcPlus4DNext = '0;
      validDNext   = 1'b0;
    end else if (loadMem) begin
      instrDNext   = imem_rdata;
      pcPlus4DNext = pcPlus4F;
      validDNext   = 1'b1;
    end else if (loadBuf) begin
      instrDNext   = fetchBufInstr;
      pcPlus4DNext = fetchBufPc;
      validDNext   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pcF           <= RESET_PC;
      fetchBufInstr <= '0;
      fetchBufPc    <= '0;
      redirReg      <= '0;
      InstrD        <= '0;
      PCPlus4D      <= '0;
      ValidD        <= 1'b0;
    end else begin
      state         <= stateNext;
      pcF           <= pcFNext;
      fetchBufInstr <= fetchBufInstrNext;
      fetchBufPc    <= fetchBufPcNext;
      redirReg      <= redirRegNext;
      InstrD        <= instrDNext;
      PCPlus4D      <= pcPlus4DNext;
      ValidD        <= validDNext;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycles push expected request/IF-ID values,
// a negedge monitor pops and compares them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCJumpD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } reqExp_t;

  typedef struct packed {
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
  } dExp_t;

  reqExp_t rQ[$];
  dExp_t   dQ[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0400)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .JumpD      (JumpD),
    .PCJumpD    (PCJumpD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Inputs change at posedge+1; expected request is for the current cycle,
  // expected IF/ID is what the following edge must load.
  task automatic step(input int unsigned rst, input int unsigned stall,
                      input int unsigned br, input logic [31:0] brT,
                      input int unsigned jp, input logic [31:0] jT,
                      input int unsigned rdy,
                      input int unsigned eReq, input logic [31:0] eAddr,
                      input int unsigned eV, input logic [31:0] eI, input logic [31:0] eP);
    reqExp_t r;
    dExp_t   d;
    reset      = (rst != 0);
    StallF     = (stall != 0);
    StallD     = (stall != 0);
    PCSrcD     = (br != 0);
    PCBranchD  = brT;
    JumpD      = (jp != 0);
    PCJumpD    = jT;
    imem_ready = (rdy != 0);
    imem_rdata = (rdy != 0) ? word(eAddr) : 32'hDEAD_BEEF;
    r.req  = (eReq != 0);
    r.addr = eAddr;
    rQ.push_back(r);
    @(posedge clk);
    #1;
    d.v = (eV != 0);
    d.i = eI;
    d.p = eP;
    dQ.push_back(d);
  endtask

  always @(negedge clk) begin
    reqExp_t r;
    dExp_t   d;
    if (dQ.size() > 0) begin
      d = dQ.pop_front();
      checks++;
      if ({ValidD, InstrD, PCPlus4D} !== {d.v, d.i, d.p}) begin
        errors++;
        $display("FAIL ifid @%0t: got V=%b I=%h P=%h want V=%b I=%h P=%h",
                 $time, ValidD, InstrD, PCPlus4D, d.v, d.i, d.p);
      end
    end
    if (rQ.size() > 0) begin
      r = rQ.pop_front();
      checks++;
      if (imem_req !== r.req) begin
        errors++;
        $display("FAIL req @%0t: got %b want %b", $time, imem_req, r.req);
      end
      if (r.req) begin
        checks++;
        if (imem_addr !== r.addr) begin
          errors++;
          $display("FAIL addr @%0t: got %h want %h", $time, imem_addr, r.addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not end, got running want finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = '0; PCJumpD = '0; imem_ready = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #1;
    // reset
    step(1,0, 0,0, 0,0, 0,  0,'h0,         0,0,0);
    step(1,0, 0,0, 0,0, 0,  0,'h0,         0,0,0);
    // streaming hits from RESET_PC
    step(0,0, 0,0, 0,0, 1,  1,'h400,       1,word('h400),'h404);
    step(0,0, 0,0, 0,0, 1,  1,'h404,       1,word('h404),'h408);
    step(0,0, 0,0, 0,0, 1,  1,'h408,       1,word('h408),'h40C);
    // jump on a hit, then 3-cycle miss at 0x10
    step(0,0, 0,0, 1,'h10, 1, 1,'h40C,     0,0,0);
    step(0,0, 0,0, 0,0, 0,  1,'h10,        0,0,0);
    step(0,0, 0,0, 0,0, 0,  1,'h10,        0,0,0);
    step(0,0, 0,0, 0,0, 0,  1,'h10,        0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'h10,        1,word('h10),'h14);
    step(0,0, 0,0, 0,0, 1,  1,'h14,        1,word('h14),'h18);
    step(0,0, 0,0, 0,0, 1,  1,'h18,        1,word('h18),'h1C);
    step(0,0, 0,0, 0,0, 1,  1,'h1C,        1,word('h1C),'h20);
    // jump beats branch while 0x20 hits
    step(0,0, 1,'h300, 1,'h200, 1, 1,'h20, 0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'h200,       1,word('h200),'h204);
    // branch to 0x30, then branch to 0x80 while 0x30 misses -> DRAIN
    step(0,0, 1,'h30, 0,0, 1, 1,'h204,     0,0,0);
    step(0,0, 1,'h80, 0,0, 0, 1,'h30,      0,0,0);
    step(0,0, 0,0, 1,'h500, 0, 1,'h30,     0,0,0);
    step(0,1, 1,'h600, 0,0, 0, 1,'h30,     0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'h30,        0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'h80,        1,word('h80),'h84);
    step(0,0, 0,0, 0,0, 1,  1,'h84,        1,word('h84),'h88);
    // miss completes under StallD -> BUF, drained when stall drops
    step(0,0, 0,0, 0,0, 0,  1,'h88,        0,0,0);
    step(0,1, 0,0, 0,0, 1,  1,'h88,        0,0,0);
    step(0,1, 0,0, 0,0, 0,  0,'h0,         0,0,0);
    step(0,0, 0,0, 0,0, 0,  0,'h0,         1,word('h88),'h8C);
    step(0,0, 0,0, 0,0, 1,  1,'h8C,        1,word('h8C),'h90);
    // stalled branch is ignored, IF/ID held
    step(0,1, 1,'h100, 0,0, 1, 0,'h0,      1,word('h8C),'h90);
    step(0,1, 1,'h100, 0,0, 1, 0,'h0,      1,word('h8C),'h90);
    step(0,0, 0,0, 0,0, 1,  1,'h90,        1,word('h90),'h94);
    // reset while draining
    step(0,0, 1,'h120, 0,0, 0, 1,'h94,     0,0,0);
    step(1,0, 0,0, 0,0, 0,  0,'h0,         0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'h400,       1,word('h400),'h404);
    // PC wrap-around
    step(0,0, 0,0, 1,'hFFFF_FFFC, 1, 1,'h404, 0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'hFFFF_FFFC, 1,word('hFFFF_FFFC),'h0);
    step(0,0, 0,0, 0,0, 1,  1,'h0,         1,word('h0),'h4);
    // redirect while holding a buffered word discards it
    step(0,0, 0,0, 0,0, 0,  1,'h4,         0,0,0);
    step(0,1, 0,0, 0,0, 1,  1,'h4,         0,0,0);
    step(0,0, 0,0, 1,'h60, 0, 0,'h0,       0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'h60,        1,word('h60),'h64);
    // redirect on the cycle a miss completes
    step(0,0, 0,0, 0,0, 0,  1,'h64,        0,0,0);
    step(0,0, 1,'h70, 0,0, 1, 1,'h64,      0,0,0);
    step(0,0, 0,0, 0,0, 1,  1,'h70,        1,word('h70),'h74);
    step(0,0, 0,0, 0,0, 1,  1,'h74,        1,word('h74),'h78);
    @(negedge clk);
    #1;
    checks++;
    if (rQ.size() != 0 || dQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", rQ.size(), dQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
